// File: rtl/imem_load_arbiter.sv
// Instruction memory port arbiter: core fetch vs. program loader write stream.
// Optional IMEM_LOAD_CHECKSUM_EN adds a running load_csum of accepted words.
module imem_load_arbiter #(
  parameter int IMEM_BITS = 10,
  parameter int IMEM_SIZE = 1 << IMEM_BITS,
  parameter int LEN_W     = IMEM_BITS + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic [31:0]          fetch_addr,
  output logic                 fetch_stall,
  output logic                 fetch_valid,
  output logic [31:0]          fetch_data,
  input  logic                 load_start,
  input  logic [IMEM_BITS-1:0] load_base,
  input  logic [LEN_W-1:0]     load_len,
  input  logic                 ld_valid,
  input  logic [31:0]          ld_data,
  output logic                 ld_ready,
  output logic                 load_busy,
  output logic                 load_done,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [31:0]          load_csum,
`endif
  output logic [IMEM_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] SIZE_L = LEN_W'(IMEM_SIZE);
  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

  state_t               state;
  logic [IMEM_BITS-1:0] ptr;
  logic [LEN_W-1:0]     remaining;
  logic [LEN_W-1:0]     len_clamp;
  logic                 in_load;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^fetch_addr[31:IMEM_BITS];

  // Lengths beyond the memory depth would only rewrite the same words.
  assign len_clamp = (load_len > SIZE_L) ? SIZE_L : load_len;

  assign in_load     = (state == LOAD);
  assign ld_ready    = in_load;
  assign load_busy   = in_load;
  assign load_done   = (state == DONE);
  assign mem_we      = in_load & ld_valid;
  assign mem_wdata   = ld_data;
  assign mem_addr    = in_load ? ptr : fetch_addr[IMEM_BITS-1:0];
  assign fetch_stall = fetch_req & (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      remaining   <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      load_csum   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          fetch_valid <= fetch_req;
          if (fetch_req)
            fetch_data <= mem_rdata;
          if (load_start) begin
            ptr       <= load_base;
            remaining <= len_clamp;
            state     <= (len_clamp != '0) ? LOAD : DONE;
`ifdef IMEM_LOAD_CHECKSUM_EN
            load_csum <= '0;
`endif
          end
        end
        LOAD: begin
          fetch_valid <= 1'b0;
          if (ld_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - ONE_L;
`ifdef IMEM_LOAD_CHECKSUM_EN
            load_csum <= load_csum + ld_data;
`endif
            if (remaining == ONE_L)
              state <= DONE;
          end
        end
        DONE: begin
          fetch_valid <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          fetch_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a 16-word memory model.
// Define IMEM_LOAD_CHECKSUM_EN to also exercise load_csum.
module tb_imem_load_arbiter;

  localparam int IB = 4;
  localparam int LW = IB + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_stall, fetch_valid;
  logic [31:0]   fetch_data;
  logic          load_start = 1'b0;
  logic [IB-1:0] load_base = '0;
  logic [LW-1:0] load_len = '0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready, load_busy, load_done;
  logic [IB-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]   load_csum;
`endif

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  imem_load_arbiter #(.IMEM_BITS(IB)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data),
    .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .load_busy(load_busy), .load_done(load_done),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .load_csum(load_csum),
`endif
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;

  // Event monitor sampled at the active edge
  int cyc = 0, wr_total = 0, busy_total = 0, done_total = 0;
  int we_bad = 0, stall_bad = 0;
  int last_we_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [IB-1:0] wr_log [256];

  always @(posedge clk) begin
    cyc++;
    if (mem_we) begin
      if (wr_total < 256) wr_log[wr_total] = mem_addr;
      wr_total++;
      last_we_cyc = cyc;
      if (!load_busy) we_bad++;
    end
    if (load_busy) busy_total++;
    if (load_busy && fetch_req && !fetch_stall) stall_bad++;
    if (load_done) begin
      done_total++;
      done_cyc = cyc;
    end
    if (load_start) start_cyc = cyc;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [3:0] b, input int i);
    return 32'h5A00_0000 | {20'd0, b, 8'd0} | 32'(i);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    fetch_req = 1'b0; load_start = 1'b0; ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } f_vec_t;

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         nw;
    int         gap_after;
    int         gap_len;
    int         busy;
  } ld_vec_t;

  f_vec_t  fv [5];
  ld_vec_t lv [4];

  task automatic run_load(input ld_vec_t v);
    int w0, b0, d0, web0, stb0;
    logic [3:0] ea;
    w0 = wr_total; b0 = busy_total; d0 = done_total;
    web0 = we_bad; stb0 = stall_bad;
    @(negedge clk);
    load_start = 1'b1; load_base = v.base; load_len = v.len;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    load_start = 1'b0;
    check("fetch_with_start", {31'd0, fetch_valid}, 32'd1);
    for (int i = 0; i < v.nw; i++) begin
      if (i == v.gap_after) begin
        ld_valid = 1'b0;
        repeat (v.gap_len) @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data = word(v.base, i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    repeat (3) @(negedge clk);
    fetch_req = 1'b0;
    check("writes", 32'(wr_total - w0), 32'(v.nw));
    check("busy_cycles", 32'(busy_total - b0), 32'(v.busy));
    check("done_pulses", 32'(done_total - d0), 32'd1);
    if (v.nw > 0)
      check("done_after_write", 32'(done_cyc - last_we_cyc), 32'd1);
    else
      check("done_after_start", 32'(done_cyc - start_cyc), 32'd1);
    check("we_outside_load", 32'(we_bad - web0), 32'd0);
    check("stall_in_load", 32'(stall_bad - stb0), 32'd0);
    for (int i = 0; i < v.nw; i++) begin
      ea = v.base + 4'(i);
      check("wr_addr", {28'd0, wr_log[w0 + i]}, {28'd0, ea});
      check("mem_word", mem[ea], word(v.base, i));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = 32'hDEAD_BEEF;

    fv[0] = '{32'd5,         32'hDEAD_BEEF};
    fv[1] = '{32'd0,         32'hC0DE_0000};
    fv[2] = '{32'd15,        32'hC0DE_000F};
    fv[3] = '{32'h0000_0013, 32'hC0DE_0003};
    fv[4] = '{32'hFFFF_FFF7, 32'hC0DE_0007};

    lv[0] = '{4'd2,  5'd3,  3,  -1, 0, 3};
    lv[1] = '{4'd14, 5'd4,  4,   2, 1, 5};
    lv[2] = '{4'd7,  5'd0,  0,  -1, 0, 0};
    lv[3] = '{4'd3,  5'd31, 16, -1, 0, 16};

    #1;
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_fetch_data", fetch_data, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_busy", {31'd0, load_busy}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = fv[k].addr;
      #1 check("fetch_stall", {31'd0, fetch_stall}, 32'd0);
      @(posedge clk); #1;
      check("fetch_valid", {31'd0, fetch_valid}, 32'd1);
      check("fetch_data", fetch_data, fv[k].exp);
      @(negedge clk);
      fetch_req = 1'b0;
      @(posedge clk); #1;
      check("fetch_idle_valid", {31'd0, fetch_valid}, 32'd0);
      check("fetch_data_hold", fetch_data, fv[k].exp);
    end

    for (int k = 0; k < 4; k++) begin
      apply_reset();
      run_load(lv[k]);
    end

    // Reset in the middle of a 5-word load after 2 words
    apply_reset();
    begin
      int d0;
      d0 = done_total;
      @(negedge clk);
      load_start = 1'b1; load_base = 4'd6; load_len = 5'd5;
      fetch_req = 1'b1; fetch_addr = 32'd1;
      @(negedge clk);
      load_start = 1'b0; fetch_req = 1'b0;
      ld_valid = 1'b1; ld_data = 32'h0000_0111;
      @(negedge clk);
      ld_data = 32'h0000_0222;
      @(negedge clk);
      check("mid_busy", {31'd0, load_busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, load_busy}, 32'd0);
      check("abort_ready", {31'd0, ld_ready}, 32'd0);
      check("abort_we", {31'd0, mem_we}, 32'd0);
      check("abort_done", {31'd0, load_done}, 32'd0);
      check("abort_fvalid", {31'd0, fetch_valid}, 32'd0);
      check("abort_fdata", fetch_data, 32'd0);
      ld_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done_total - d0), 32'd0);
      fetch_req = 1'b1; fetch_addr = 32'd6;
      @(posedge clk); #1;
      check("abort_refetch_v", {31'd0, fetch_valid}, 32'd1);
      check("abort_refetch_d", fetch_data, 32'h0000_0111);
      check("abort_mem7", mem[7], 32'h0000_0222);
      @(negedge clk);
      fetch_req = 1'b0;
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    apply_reset();
    #1 check("csum_rst", load_csum, 32'd0);
    @(negedge clk);
    load_start = 1'b1; load_base = 4'd0; load_len = 5'd2;
    @(negedge clk);
    load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
    @(negedge clk);
    ld_data = 32'h0000_0002;
    @(negedge clk);
    ld_valid = 1'b0;
    check("csum_done", {31'd0, load_done}, 32'd1);
    repeat (2) @(negedge clk);
    check("csum_value", load_csum, 32'h0000_0001);
    repeat (3) @(negedge clk);
    check("csum_hold", load_csum, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
- Sits in front of the single-port instruction memory and shares it between two requesters: the core's fetch port (read) and a boot/test program loader (write stream).
- A small FSM owns the memory port. While a program load is in progress, fetch is stalled and the loader streams words into consecutive word addresses.
- Fetch read data is registered, giving a fixed 1-cycle fetch latency.

Parameters:
- IMEM_BITS, 10, word-index width into instruction memory.
- IMEM_SIZE, 1<<IMEM_BITS, memory depth in 32-bit words.
- LEN_W, IMEM_BITS+1, width of load length field.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fetch_req  input  1  core requests instruction read this cycle.
- fetch_addr  input  32  word index; only [IMEM_BITS-1:0] used.
- fetch_stall  output  1  fetch_req not accepted this cycle.
- fetch_valid  output  1  fetch_data valid (1 cycle after accepted req).
- fetch_data  output  32  registered instruction word.
- load_start  input  1  single-cycle pulse, begins a load.
- load_base  input  IMEM_BITS  first word index to write.
- load_len  input  LEN_W  number of words to write.
- ld_valid  input  1  loader word available.
- ld_data  input  32  loader word.
- ld_ready  output  1  arbiter accepts loader word.
- load_busy  output  1  high in LOAD state.
- load_done  output  1  1-cycle pulse when load completes.
- mem_addr  output  IMEM_BITS  memory word index.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory combinational read data.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; fetch_valid=0, fetch_data=0, load_done=0, load_busy=0, ld_ready=0, mem_we=0; word counter and write pointer cleared.
- States: IDLE, LOAD, DONE.
- IDLE:
  - mem_addr=fetch_addr[IMEM_BITS-1:0], mem_we=0, fetch_stall=0.
  - On fetch_req: fetch_data<=mem_rdata and fetch_valid<=1 at the next edge; otherwise fetch_valid<=0.
  - load_start: latch ptr<=load_base and remaining<=min(load_len, IMEM_SIZE). Next state is LOAD if the clamped length is nonzero, else DONE.
  - A fetch_req in the same cycle as load_start is still served.
- LOAD:
  - ld_ready=1, load_busy=1, fetch_stall=fetch_req, fetch_valid<=0.
  - mem_addr=ptr, mem_wdata=ld_data, mem_we=ld_valid.
  - On ld_valid: ptr<=ptr+1, wrapping modulo IMEM_SIZE (IMEM_SIZE-1 -> 0), and remaining<=remaining-1.
  - When remaining==1 and ld_valid: go to DONE.
  - ld_valid=0 cycles insert bubbles and nothing is written.
  - load_start is ignored in LOAD.
- DONE:
  - load_done=1 for exactly one cycle. ld_ready=0, mem_we=0, fetch_stall=fetch_req.
  - Next state is IDLE.
- load_done is combinational from state (DONE). load_len=0 gives IDLE -> DONE -> IDLE with no writes.
- Async reset mid-LOAD aborts the load: no load_done pulse, words already written stay in memory, and the next fetch after reset reads normally.
- mem_we is never asserted outside LOAD.
- fetch_data holds its last value when fetch_valid=0.

Optional Feature:
- IMEM_LOAD_CHECKSUM_EN defined:
  - Adds output load_csum[31:0].
  - Cleared to 0 on accepting load_start.
  - Each word accepted in LOAD updates it as load_csum <= load_csum + ld_data, mod 2^32.
  - Holds its value after DONE until the next load_start; reset value 0.
- Macro undefined: the port and the logic are absent.

Test Plan:
- Fetch only, after reset with memory preloaded (mem[5]=0xDEADBEEF): fetch_req=1, addr=5 -> the next cycle gives fetch_valid=1, fetch_data=0xDEADBEEF, fetch_stall=0.
- Load base=2, len=3, ld_data=0x11,0x22,0x33 with ld_valid continuous -> mem[2..4]=0x11,0x22,0x33, load_done pulses once 1 cycle after the 3rd write, fetch_stall=1 during LOAD.
- Wrap-around, IMEM_BITS=4, base=14, len=4 with a ld_valid gap after the 2nd word -> writes go to 14,15,0,1, no write during the gap, load_busy is high for 5 cycles.
- Edge lengths: len=0 -> load_done pulses 1 cycle after start with zero mem_we cycles. len=2*IMEM_SIZE-1 -> clamped to exactly IMEM_SIZE writes.
- Reset mid-LOAD after 2 of 5 words -> outputs go to reset values immediately, no load_done, and a subsequent fetch of the base address returns the 1st loaded word.
- With IMEM_LOAD_CHECKSUM_EN: load 0xFFFFFFFF, 0x00000002 -> load_csum=0x00000001 after DONE.
